// File: rtl/channel_selector_pkg.sv
// rtl/channel_selector_pkg.sv - shared channel encodings, widths and wrap helpers
package channel_selector_pkg;

  localparam int CHANNEL_W            = 2;
  localparam int DEBOUNCE_100MHZ_10MS = 1000000;

  typedef enum logic [CHANNEL_W-1:0] {
    CH_0 = 2'b00,
    CH_1 = 2'b01,
    CH_2 = 2'b10,
    CH_3 = 2'b11
  } channel_e;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'b00,
    STEP_NEXT = 2'b01,
    STEP_PREV = 2'b10
  } step_e;

  // Wrap is compared against the last legal channel so NUM_CHANNELS < 4 never overflows into unused codes.
  function automatic logic [CHANNEL_W-1:0] wrap_next(input logic [CHANNEL_W-1:0] ch,
                                                     input logic [CHANNEL_W-1:0] last);
    return (ch == last) ? CH_0 : ch + 1'b1;
  endfunction

  function automatic logic [CHANNEL_W-1:0] wrap_prev(input logic [CHANNEL_W-1:0] ch,
                                                     input logic [CHANNEL_W-1:0] last);
    return (ch == CH_0) ? last : ch - 1'b1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser, counting debouncer and rise detector
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw_in;
      s2      <= s1;
      level_q <= level;
      // Any sample agreeing with the current level restarts the stability count.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/channel_selector.sv
// rtl/channel_selector.sv - debounced next/prev buttons stepping a wrap-around channel select
module channel_selector
  import channel_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS,
  parameter int CNT_W           = 20,
  parameter int NUM_CHANNELS    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  output logic [CHANNEL_W-1:0] channel,
  output logic                 channel_changed
);

  localparam logic [CHANNEL_W-1:0] LAST_CH = CHANNEL_W'(NUM_CHANNELS - 1);

  logic  next_level;
  logic  prev_level;
  logic  next_press;
  logic  prev_press;
  logic  unused_levels;
  step_e step;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_next (
    .clk   (clk),
    .rst   (rst),
    .raw_in(btn_next),
    .level (next_level),
    .press (next_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_prev (
    .clk   (clk),
    .rst   (rst),
    .raw_in(btn_prev),
    .level (prev_level),
    .press (prev_press)
  );

  assign unused_levels = next_level ^ prev_level;

  // Coincident presses cancel rather than favouring either button.
  always_comb begin
    step = STEP_HOLD;
    if (next_press && !prev_press) begin
      step = STEP_NEXT;
    end else if (prev_press && !next_press) begin
      step = STEP_PREV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      channel         <= CH_0;
      channel_changed <= 1'b0;
    end else begin
      case (step)
        STEP_NEXT: begin
          channel         <= wrap_next(channel, LAST_CH);
          channel_changed <= 1'b1;
        end
        STEP_PREV: begin
          channel         <= wrap_prev(channel, LAST_CH);
          channel_changed <= 1'b1;
        end
        default: begin
          channel_changed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/channel_selector.md
Name: channel_selector

Overview:
- Produces the 2-bit channel select that the seven-segment controller and VGA channel mux consume; it is the producer end of that channel interface.
- Takes two raw board pushbuttons (next/prev), synchronises and debounces them, and detects presses.
- Steps a wrap-around channel register on each press.
- Emits a one-cycle strobe whenever the channel value changes.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its debounced level before the level flips (10 ms at 100 MHz); legal range >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- NUM_CHANNELS, 4, number of selectable channels; legal range 2..4.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low.
- btn_next  input  1  raw pushbutton, asynchronous to clk, active-high; advances the channel.
- btn_prev  input  1  raw pushbutton, asynchronous to clk, active-high; decrements the channel.
- channel  output  2  current channel select, registered.
- channel_changed  output  1  one-cycle strobe, high in the cycle channel first shows a new value.

Interface (already decided): one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst low at a clk edge): all state clears.
  - Synchroniser flops = 0, debounced levels = 0 (released), debounce counters = 0, delayed debounced levels = 0.
  - channel = 0, channel_changed = 0.
  - Reset overrides all other activity, including mid-debounce or mid-press. A button held through reset release is treated as pressed: it debounces high and generates one press.
- Synchroniser: each button passes through two flops (s1, s2) before any use.
- Debouncer, per button, each edge:
  - if s2 == db: cnt <= 0
  - else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0
  - else: cnt <= cnt+1
  - Any bounce back to db before the count completes restarts the count from 0.
- Press detect: press = db & ~db_q, where db_q is db delayed one cycle. This gives exactly one pulse per debounced 0->1 transition. Releases generate nothing.
- Channel update, registered, in the cycle after press is high:
  - press_next only: channel <= (channel == NUM_CHANNELS-1) ? 0 : channel+1; channel_changed <= 1.
  - press_prev only: channel <= (channel == 0) ? NUM_CHANNELS-1 : channel-1; channel_changed <= 1.
  - Both presses in the same cycle: no change, channel_changed <= 0.
  - Neither press: hold, channel_changed <= 0.
- Latency: raw input first sampled high at edge 0 and held stable gives:
  - db high after edge DEBOUNCE_CYCLES+1;
  - channel updated and channel_changed high after edge DEBOUNCE_CYCLES+2, for exactly one cycle.
- Holding a button produces one step only; there is no auto-repeat.
- Overlapping presses: presses on different buttons in different cycles each take effect, in order.
- Arithmetic: channel is stored in 2 bits; wrap is explicit against NUM_CHANNELS-1, never by natural overflow. channel never exceeds NUM_CHANNELS-1.

Decomposition:
- Shared package:
  - CHANNEL_W = 2
  - default debounce constant DEBOUNCE_100MHZ_10MS = 1000000
  - channel encodings CH_0..CH_3 (2'b00..2'b11), also used by the seven-segment controller.
- Sub-module: button_debouncer (parameters DEBOUNCE_CYCLES, CNT_W; ports clk, rst, raw_in, level, press). It contains the synchroniser, counter, level register and rise detector. channel_selector instantiates it twice and holds the channel register plus the wrap logic.

Test Plan (DEBOUNCE_CYCLES=4, NUM_CHANNELS=4 unless stated):
- Reset: hold rst=0 for 3 cycles with btn_next=1 -> channel=0 and channel_changed=0 during reset. After release, exactly one step to channel=1 at edge 6 after the first sampling edge.
- Clean single press: btn_next 0->1 sampled at edge 0, held for 20 cycles -> channel 0->1 after edge 6; channel_changed high for exactly one cycle; no further change while held or on release.
- Bounce rejection: btn_next toggles 1,0,1,1,0,1 then holds 1 -> no change until 4 consecutive synchronised highs; then exactly one step and one strobe. A pulse of 3 cycles -> no change at all.
- Wrap both ways: 4 next presses from 0 -> 1,2,3,0. Then one prev press -> 3. With NUM_CHANNELS=3: next from 2 -> 0, prev from 0 -> 2.
- Simultaneous: both buttons rise on the same sampling edge and held -> channel unchanged, channel_changed stays 0. Staggered by 1 cycle (next first) -> +1 then -1, back to original value, two separate strobes.
- Reset mid-debounce: assert rst at count 2 of a next press, then release with the button released -> no channel change, counters restart from 0.
